alu_result_fifo: RTL and testbench

- Downstream stage of the 4-bit ALU logic units (AND/OR/etc.).
- Captures each ALU result word with its Z and CF flags into a small first-word-fall-through FIFO.
- Presents queued results to the consumer (register file / display stage) with a valid/ready handshake.
- Also keeps a sticky carry flag and a sticky overflow-error flag for software/debug.

---
 rtl/alu_result_fifo_if.sv | 31 +++
 rtl/alu_result_fifo.sv | 88 ++++++++
 tb/tb_alu_result_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and the consumer.
// The master modport is the producer/consumer side; the slave modport is the FIFO itself.
interface alu_result_fifo_if #(
    parameter int DW = 4,
    parameter int CW = 3
);
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] RES;
    logic          Z_IN;
    logic          CF_IN;
    logic          RD_VALID;
    logic          RD_READY;
    logic [DW-1:0] RD_DATA;
    logic          RD_Z;
    logic          RD_CF;
    logic [CW-1:0] COUNT;
    logic          STICKY_CF;
    logic          CLR_STICKY;
    logic          OVF_ERR;

    modport master (
        output IN_VALID, RES, Z_IN, CF_IN, RD_READY, CLR_STICKY,
        input  IN_READY, RD_VALID, RD_DATA, RD_Z, RD_CF, COUNT, STICKY_CF, OVF_ERR
    );

    modport slave (
        input  IN_VALID, RES, Z_IN, CF_IN, RD_READY, CLR_STICKY,
        output IN_READY, RD_VALID, RD_DATA, RD_Z, RD_CF, COUNT, STICKY_CF, OVF_ERR
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU result words and their Z/CF flags,
// with a sticky carry flag and a sticky overflow-error flag.
module alu_result_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    alu_result_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] res;
        logic          z;
        logic          cf;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;
    logic          in_ready, rd_valid;
    entry_t        head;

    // Handshake depends on registered occupancy only, never on IN_VALID/RD_READY.
    assign in_ready = (count_q != CW'(DEPTH));
    assign rd_valid = (count_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        push     = bus.IN_VALID & in_ready;
        pop      = rd_valid & bus.RD_READY;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set has priority over clear.
        sticky_d = (push & bus.CF_IN) | (sticky_q & ~bus.CLR_STICKY);
        ovf_d    = ovf_q | (bus.IN_VALID & ~in_ready);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; the head output is masked while empty.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= '{res: bus.RES, z: bus.Z_IN, cf: bus.CF_IN};
    end

    always_comb begin
        head = '0;
        if (rd_valid) head = mem_q[rd_ptr_q];
    end

    assign bus.IN_READY  = in_ready;
    assign bus.RD_VALID  = rd_valid;
    assign bus.RD_DATA   = head.res;
    assign bus.RD_Z      = head.z;
    assign bus.RD_CF     = head.cf;
    assign bus.COUNT     = count_q;
    assign bus.STICKY_CF = sticky_q;
    assign bus.OVF_ERR   = ovf_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: a queue model predicts occupancy, head entry,
// sticky carry and overflow error, checked once per cycle before the rising edge.
module tb_alu_result_fifo;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst_n;

    alu_result_fifo_if #(.DW(DW), .CW(CW)) bus ();

    alu_result_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW+1:0] sb[$];
    logic          m_sticky;
    logic          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [DW+1:0] exp_head;
        exp_head = (sb.size() != 0) ? sb[0] : '0;
        check("in_ready",  32'(bus.IN_READY),  32'(sb.size() != DEPTH));
        check("rd_valid",  32'(bus.RD_VALID),  32'(sb.size() != 0));
        check("count",     32'(bus.COUNT),     32'(sb.size()));
        check("rd_head",   32'({bus.RD_DATA, bus.RD_Z, bus.RD_CF}), 32'(exp_head));
        check("sticky_cf", 32'(bus.STICKY_CF), 32'(m_sticky));
        check("ovf_err",   32'(bus.OVF_ERR),   32'(m_ovf));
    endtask

    // One clock cycle: drive inputs just after an edge, check state before the next edge,
    // then advance the model exactly as the FIFO should on that edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] res, input logic z,
                         input logic cf, input logic rr, input logic clr);
        logic do_push, do_pop;
        bus.IN_VALID   = iv;
        bus.RES        = res;
        bus.Z_IN       = z;
        bus.CF_IN      = cf;
        bus.RD_READY   = rr;
        bus.CLR_STICKY = clr;
        #3;
        check_state();
        do_pop  = (sb.size() != 0) && rr;
        do_push = iv && (sb.size() != DEPTH);
        if (iv && sb.size() == DEPTH) m_ovf = 1'b1;
        m_sticky = (do_push && cf) || (m_sticky && !clr);
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back({res, z, cf});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] res, input logic z, input logic cf);
        cycle(1'b1, res, z, cf, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, '0, 1'b0, 1'b0, rr, 1'b0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_sticky = 1'b0;
        m_ovf    = 1'b0;
    endtask

    initial begin
        bus.IN_VALID   = 1'b0;
        bus.RES        = '0;
        bus.Z_IN       = 1'b0;
        bus.CF_IN      = 1'b0;
        bus.RD_READY   = 1'b0;
        bus.CLR_STICKY = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #3;
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single push, fall-through on the next cycle, then pop back to empty
        push(4'hA, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // 2: fill, overflow drop, drain in order
        for (int i = 1; i <= 4; i++) push(DW'(i), 1'b0, 1'b0);
        push(4'h5, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // 3: two queued, simultaneous push/pop for 10 cycles across pointer wrap
        push(4'hE, 1'b1, 1'b0);
        push(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), (i == 0), 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // 4: sticky carry set wins over clear, then clear alone
        cycle(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);

        // 5: asynchronous reset mid-cycle with three entries queued
        push(4'h1, 1'b0, 1'b1);
        push(4'h2, 1'b1, 1'b0);
        push(4'h3, 1'b0, 1'b0);
        bus.IN_VALID = 1'b0;
        bus.RD_READY = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(4'h7, 1'b1, 1'b1);
        idle(1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 6: full with push and pop together: pop only, overflow flagged
        for (int i = 0; i < 4; i++)
            push(DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
